// File: rtl/serial_pkg.sv
// serial_pkg: serial-link state encoding and defaults shared by transmitter and receiver
package serial_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CLKS_PER_BIT = 4;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;
  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} parity_t;
  localparam parity_t PARITY_MODE = EVEN;
endpackage

// File: rtl/s2p_bit_timer.sv
// s2p_bit_timer: bit-period counter with half-period mode; ticks at each sample point
module s2p_bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic half,
  output logic tick
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  logic [TW-1:0] cnt;
  assign tick = cnt == (half ? TW'(CLKS_PER_BIT / 2 - 1) : TW'(CLKS_PER_BIT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: framed serial receiver (start, LSB-first data, parity, stop)
module serial_to_parallel_rx
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] sh;
  logic par, tick;
  s2p_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == IDLE || state == WAIT_HIGH),
    .half (state == START),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      sh         <= '0;
      par        <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (!sin) begin
          state <= START;
          busy  <= 1'b1;
        end
        START: if (tick) begin
          state <= sin ? IDLE : DATA;
          busy  <= !sin;
          idx   <= '0;
        end
        DATA: if (tick) begin
          sh    <= (sh >> 1) | (WIDTH'(sin) << (WIDTH - 1));
          idx   <= idx + 1'b1;
          state <= idx == IW'(WIDTH - 1) ? PARITY : DATA;
        end
        PARITY: if (tick) begin
          par   <= sin;
          state <= STOP;
        end
        STOP: if (tick) begin
          data_out   <= sh;
          parity_err <= par != ((^sh) ^ (PARITY_MODE == ODD));
          frame_err  <= !sin;
          valid      <= 1'b1;
          busy       <= 1'b0;
          state      <= sin ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: if (sin) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx: directed frame checks for serial_to_parallel_rx (WIDTH=8, CLKS_PER_BIT=4)
module tb_serial_to_parallel_rx;
  logic clk = 1'b0, rst_n = 1'b0, sin = 1'b1;
  logic [7:0] data_out;
  logic valid, parity_err, frame_err, busy;
  int tests = 0, failed = 0, cyc = 0, vcyc = 0, first_v = 0;
  serial_to_parallel_rx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .data_out  (data_out),
    .valid     (valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Drives n cycles of a frame; edge k is the k-th edge after the start bit is first sampled.
  task automatic send(input string tag, input logic [7:0] d, input logic pflip, input logic stop_b,
                      input int n, input logic [7:0] ed, input logic ep, input logic ef);
    logic [10:0] bits;
    int nv = 0;
    bits = {stop_b, (^d) ^ pflip, d, 1'b0};
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sin = bits[k / 4];
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        nv++;
        vcyc = cyc;
      end
      if (k == 0) chk({tag, ".busy0"}, busy, 1);
      if (k == 41) begin
        chk({tag, ".valid41"}, valid, 0);
        chk({tag, ".busy41"}, busy, 1);
      end
      if (k == 42) begin
        chk({tag, ".valid42"}, valid, 1);
        chk({tag, ".data"}, data_out, ed);
        chk({tag, ".perr"}, parity_err, ep);
        chk({tag, ".ferr"}, frame_err, ef);
        chk({tag, ".busy42"}, busy, 0);
      end
    end
    if (n == 44) chk({tag, ".nvalid"}, nv, 1);
  endtask
  initial begin
    int nv;
    #3;
    chk("rst.data", data_out, 0);
    chk("rst.valid", valid, 0);
    chk("rst.perr", parity_err, 0);
    chk("rst.ferr", frame_err, 0);
    chk("rst.busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send("a5", 8'hA5, 1'b0, 1'b1, 44, 8'hA5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("a5.hold", data_out, 8'hA5);
    send("3c_bad", 8'h3C, 1'b1, 1'b1, 44, 8'h3C, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("3c_bad.hold", parity_err, 1);
    send("3c_ok", 8'h3C, 1'b0, 1'b1, 44, 8'h3C, 1'b0, 1'b0);
    send("81_brk", 8'h81, 1'b0, 1'b0, 44, 8'h81, 1'b0, 1'b1);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sin = 1'b0;
      @(posedge clk);
      #1;
      if (valid === 1'b1) nv++;
    end
    chk("brk.nvalid", nv, 0);
    chk("brk.busy", busy, 0);
    chk("brk.ferr", frame_err, 1);
    @(negedge clk);
    sin = 1'b1;
    send("55", 8'h55, 1'b0, 1'b1, 44, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    sin = 1'b0;
    @(posedge clk);
    #1;
    chk("glitch.busy0", busy, 1);
    @(negedge clk);
    sin = 1'b1;
    @(posedge clk);
    #1;
    chk("glitch.busy1", busy, 1);
    @(posedge clk);
    #1;
    chk("glitch.busy2", busy, 0);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) nv++;
    end
    chk("glitch.nvalid", nv, 0);
    chk("glitch.data", data_out, 8'h55);
    send("ff_rst", 8'hFF, 1'b0, 1'b1, 21, 8'h00, 1'b0, 1'b0);
    chk("ff_rst.busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst.data", data_out, 0);
    chk("arst.valid", valid, 0);
    chk("arst.perr", parity_err, 0);
    chk("arst.ferr", frame_err, 0);
    chk("arst.busy", busy, 0);
    @(negedge clk);
    sin = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send("0f", 8'h0F, 1'b0, 1'b1, 44, 8'h0F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    send("b2b_01", 8'h01, 1'b0, 1'b1, 44, 8'h01, 1'b0, 1'b0);
    first_v = vcyc;
    send("b2b_ff", 8'hFF, 1'b0, 1'b1, 44, 8'hFF, 1'b0, 1'b0);
    chk("b2b.gap", vcyc - first_v, 44);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
